// File: rtl/sort_7_stream_ctrl_pkg.sv
// Shared types for the 7-word stream sorter: word type, pad value, FSM states,
// and the compare-exchange schedule of the 16-comparator / depth-6 network.
package sort_pkg;

  localparam int SORT_N = 7;
  localparam int NUM_CE = 16;

  typedef logic [31:0] data_t;
  typedef data_t [SORT_N-1:0] batch_t;

  localparam data_t PAD_VALUE = '1;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } sort_state_t;

  // {lo, hi} slot pair for comparator k; layers are listed in order so applying
  // them one after another is equivalent to the parallel network.
  function automatic logic [5:0] ce_pair(input int k);
    case (k)
      0:       ce_pair = {3'd0, 3'd6};
      1:       ce_pair = {3'd2, 3'd3};
      2:       ce_pair = {3'd4, 3'd5};
      3:       ce_pair = {3'd0, 3'd2};
      4:       ce_pair = {3'd1, 3'd4};
      5:       ce_pair = {3'd3, 3'd6};
      6:       ce_pair = {3'd0, 3'd1};
      7:       ce_pair = {3'd2, 3'd5};
      8:       ce_pair = {3'd3, 3'd4};
      9:       ce_pair = {3'd1, 3'd2};
      10:      ce_pair = {3'd4, 3'd6};
      11:      ce_pair = {3'd2, 3'd3};
      12:      ce_pair = {3'd4, 3'd5};
      13:      ce_pair = {3'd1, 3'd2};
      14:      ce_pair = {3'd3, 3'd4};
      15:      ce_pair = {3'd5, 3'd6};
      default: ce_pair = {3'd0, 3'd0};
    endcase
  endfunction

endpackage

// File: rtl/sort_7_stream_ctrl_if.sv
// Valid/ready word stream with an end-of-batch marker.
// master drives valid/data/last, slave drives ready.
interface sort_7_stream_ctrl_if #(
  parameter int W = 32
) ();

  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/sort_7_stream_ctrl_sorter.sv
// 7-input combinational sorting network (16 compare-exchange, depth 6), ascending unsigned.
// Zero latency, no flow control: outputs follow inputs within the cycle.
module sort_7_16_6
  import sort_pkg::*;
(
  input  batch_t data_i,
  output batch_t data_o
);

  logic [5:0] pair_c;
  logic [2:0] lo_c;
  logic [2:0] hi_c;
  data_t      tmp_c;

  always_comb begin
    data_o = data_i;
    pair_c = '0;
    lo_c   = '0;
    hi_c   = '0;
    tmp_c  = '0;
    for (int k = 0; k < NUM_CE; k++) begin
      pair_c = ce_pair(k);
      lo_c   = pair_c[5:3];
      hi_c   = pair_c[2:0];
      if (data_o[lo_c] > data_o[hi_c]) begin
        tmp_c        = data_o[lo_c];
        data_o[lo_c] = data_o[hi_c];
        data_o[hi_c] = tmp_c;
      end
    end
  end

endmodule

// File: rtl/sort_7_stream_ctrl.sv
// Gathers up to 7 words, sorts them, replays ascending; out_valid 1+SORT_LATENCY cycles
// after the closing accept. Input stalls (ready=0) during SORT/DRAIN; output honours out_ready.
module sort_7_stream_ctrl
  import sort_pkg::*;
#(
  parameter int N            = SORT_N,
  parameter int W            = 32,
  parameter int SORT_LATENCY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sort_7_stream_ctrl_if.slave  in_if,
  sort_7_stream_ctrl_if.master out_if,
  output logic                 busy_o,
  output logic [15:0]          batch_cnt_o
);

  localparam int                 IDX_W    = $clog2(N);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N - 1);
  localparam logic [3:0]         LAT_INIT = 4'(SORT_LATENCY);

  sort_state_t      state_q, state_d;
  batch_t           slot_q;
  batch_t           out_buf_q;
  batch_t           sorted_c;
  logic [IDX_W-1:0] wr_idx_q;
  logic [IDX_W-1:0] rd_idx_q;
  logic [IDX_W-1:0] count_q;
  logic [3:0]       lat_q;
  logic [15:0]      batch_cnt_q;

  logic in_rdy_c;
  logic out_vld_c;
  logic busy_c;
  logic out_last_c;
  logic in_hs;
  logic close_batch;
  logic out_hs;
  logic drain_done;

  sort_7_16_6 u_sorter (
    .data_i (slot_q),
    .data_o (sorted_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (close_batch)   state_d = SORT;
      SORT:    if (lat_q == 4'd0) state_d = DRAIN;
      DRAIN:   if (drain_done)    state_d = FILL;
      default:                    state_d = FILL;
    endcase
  end

  // in_ready is gated by rst_n so it stays low for the whole reset pulse.
  always_comb begin
    in_rdy_c  = 1'b0;
    out_vld_c = 1'b0;
    busy_c    = 1'b0;
    case (state_q)
      FILL:    in_rdy_c = rst_n;
      SORT:    busy_c   = 1'b1;
      DRAIN: begin
        out_vld_c = 1'b1;
        busy_c    = 1'b1;
      end
      default: ;
    endcase
  end

  assign in_hs       = in_if.valid & in_rdy_c;
  assign close_batch = in_hs & ((wr_idx_q == LAST_IDX) | in_if.last);
  assign out_last_c  = (rd_idx_q == (count_q - IDX_W'(1)));
  assign out_hs      = out_vld_c & out_if.ready;
  assign drain_done  = out_hs & out_last_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q      <= '0;
      out_buf_q   <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      lat_q       <= '0;
      batch_cnt_q <= '0;
    end else begin
      if (in_hs) begin
        slot_q[wr_idx_q] <= data_t'(in_if.data);
        wr_idx_q         <= close_batch ? '0 : wr_idx_q + IDX_W'(1);
      end
      // Unused slots get PAD so they sort above every real word and are never replayed.
      if (close_batch) begin
        count_q <= wr_idx_q + IDX_W'(1);
        lat_q   <= LAT_INIT;
        for (int i = 0; i < N; i++) begin
          if (IDX_W'(i) > wr_idx_q) slot_q[i] <= PAD_VALUE;
        end
      end
      if (state_q == SORT) begin
        if (lat_q == 4'd0) begin
          out_buf_q <= sorted_c;
          rd_idx_q  <= '0;
        end else begin
          lat_q <= lat_q - 4'd1;
        end
      end
      if (out_hs) rd_idx_q <= rd_idx_q + IDX_W'(1);
      if (drain_done) batch_cnt_q <= batch_cnt_q + 16'd1;
    end
  end

  assign in_if.ready  = in_rdy_c;
  assign out_if.valid = out_vld_c;
  assign out_if.data  = out_vld_c ? W'(out_buf_q[rd_idx_q]) : '0;
  assign out_if.last  = out_vld_c & out_last_c;
  assign busy_o       = busy_c;
  assign batch_cnt_o  = batch_cnt_q;

endmodule

// File: tb/tb_sort_7_stream_ctrl.sv
// Directed plus randomized batches against a queue-based sorting model; two DUTs
// cover SORT_LATENCY 0 and 2.
module tb_sort_7_stream_ctrl;

  typedef logic [31:0] word_t;
  typedef word_t word_q_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sort_7_stream_ctrl_if #(.W(32)) in0 ();
  sort_7_stream_ctrl_if #(.W(32)) out0 ();
  sort_7_stream_ctrl_if #(.W(32)) in1 ();
  sort_7_stream_ctrl_if #(.W(32)) out1 ();

  logic        busy0, busy1;
  logic [15:0] bc0, bc1;

  sort_7_stream_ctrl #(.N(7), .W(32), .SORT_LATENCY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_if(in0), .out_if(out0), .busy_o(busy0), .batch_cnt_o(bc0)
  );

  sort_7_stream_ctrl #(.N(7), .W(32), .SORT_LATENCY(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_if(in1), .out_if(out1), .busy_o(busy1), .batch_cnt_o(bc1)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_bc0 = 16'd0;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain insertion sort of the words actually sent.
  function automatic word_q_t model_sort(input word_q_t w);
    word_q_t s;
    int p;
    for (int i = 0; i < w.size(); i++) begin
      p = 0;
      while (p < s.size() && s[p] <= w[i]) p++;
      s.insert(p, w[i]);
    end
    return s;
  endfunction

  task automatic send0(input word_q_t w, input bit use_last);
    int t;
    for (int i = 0; i < w.size(); i++) begin
      t = 0;
      in0.valid = 1'b1;
      in0.data  = w[i];
      in0.last  = use_last && (i == w.size() - 1);
      while (!in0.ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("send0_timeout", in0.ready, 1);
      @(negedge clk);
    end
    in0.valid = 1'b0;
    in0.last  = 1'b0;
    in0.data  = $urandom;
  endtask

  task automatic recv0(input word_q_t exp, input int full_len, input bit stall);
    int idx;
    int guard;
    idx   = 0;
    guard = 0;
    while (idx < exp.size() && guard < 300) begin
      guard++;
      out0.ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (out0.valid) begin
        chk("out_data", out0.data, exp[idx]);
        chk("out_last", out0.last, (idx == full_len - 1));
        chk("in_ready_drain", in0.ready, 0);
        if (out0.ready) idx++;
      end else begin
        chk("out_data_idle", out0.data, 0);
      end
      @(negedge clk);
    end
    if (idx < exp.size()) chk("recv0_timeout", idx, exp.size());
    out0.ready = 1'b0;
  endtask

  task automatic run0(input word_q_t w, input bit use_last, input bit stall);
    send0(w, use_last);
    chk("sort_valid_low", out0.valid, 0);
    chk("sort_busy", busy0, 1);
    chk("sort_in_ready", in0.ready, 0);
    @(negedge clk);
    chk("first_valid", out0.valid, 1);
    recv0(model_sort(w), w.size(), stall);
    exp_bc0++;
    chk("batch_cnt", bc0, exp_bc0);
    chk("fill_ready", in0.ready, 1);
    chk("idle_busy", busy0, 0);
    chk("idle_valid", out0.valid, 0);
  endtask

  initial begin
    word_q_t w;
    word_q_t s;
    int      len;
    int      t;
    bit      use_last;

    in0.valid = 1'b1; in0.data = 32'h1234; in0.last = 1'b0; out0.ready = 1'b1;
    in1.valid = 1'b0; in1.data = '0;       in1.last = 1'b0; out1.ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", in0.ready, 0);
    chk("rst_out_valid", out0.valid, 0);
    chk("rst_out_data", out0.data, 0);
    chk("rst_out_last", out0.last, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_batch_cnt", bc0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_in_ready1", in1.ready, 0);

    in0.valid = 1'b0; out0.ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in0.ready, 1);

    w = '{32'd7, 32'd3, 32'd9, 32'd1, 32'd8, 32'd2, 32'd5};
    run0(w, 1'b0, 1'b0);

    w = '{32'd40, 32'd10, 32'd30};
    run0(w, 1'b1, 1'b0);

    w = '{32'hFFFF_FFFF, 32'd5, 32'd5, 32'd0};
    run0(w, 1'b1, 1'b0);

    w = '{32'd6, 32'd4, 32'd2, 32'd7, 32'd1, 32'd3, 32'd5};
    run0(w, 1'b0, 1'b1);

    for (int b = 0; b < 8; b++) begin
      w.delete();
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 3))
          0:       w.push_back(32'hFFFF_FFFF);
          1:       w.push_back(word_t'($urandom_range(0, 7)));
          default: w.push_back($urandom);
        endcase
      end
      use_last = (len < 7) ? 1'b1 : 1'($urandom_range(0, 1));
      run0(w, use_last, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a drain
    w.delete();
    for (int i = 0; i < 7; i++) w.push_back($urandom);
    send0(w, 1'b0);
    @(negedge clk);
    s = model_sort(w);
    recv0(s[0:2], 7, 1'b0);
    chk("mid_drain_valid", out0.valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", out0.valid, 0);
    chk("mrst_out_data", out0.data, 0);
    chk("mrst_out_last", out0.last, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_batch_cnt", bc0, 0);
    chk("mrst_in_ready", in0.ready, 0);
    exp_bc0 = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    w = '{32'd9, 32'd8};
    run0(w, 1'b1, 1'b0);

    // SORT_LATENCY = 2 instance
    chk("lat2_idle_busy", busy1, 0);
    w.delete();
    for (int i = 0; i < 7; i++) w.push_back($urandom);
    for (int i = 0; i < 7; i++) begin
      in1.valid = 1'b1;
      in1.data  = w[i];
      t = 0;
      while (!in1.ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) chk("send1_timeout", in1.ready, 1);
      @(negedge clk);
    end
    in1.valid = 1'b0;
    chk("lat2_busy_sort", busy1, 1);
    chk("lat2_valid_e0", out1.valid, 0);
    @(negedge clk);
    chk("lat2_valid_e1", out1.valid, 0);
    @(negedge clk);
    chk("lat2_valid_e2", out1.valid, 0);
    chk("lat2_in_ready_sort", in1.ready, 0);
    @(negedge clk);
    chk("lat2_valid_e3", out1.valid, 1);
    s = model_sort(w);
    out1.ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      chk("lat2_out_valid", out1.valid, 1);
      chk("lat2_out_data", out1.data, s[i]);
      chk("lat2_out_last", out1.last, (i == 6));
      chk("lat2_busy_drain", busy1, 1);
      @(negedge clk);
    end
    out1.ready = 1'b0;
    chk("lat2_busy_done", busy1, 0);
    chk("lat2_batch_cnt", bc1, 1);
    chk("lat2_fill_ready", in1.ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
